bitrev_pingpong: RTL and testbench

//   Streaming bit-reversal reorder buffer with two ping-pong banks. One bank

---
 rtl/bitrev_pkg.sv | 27 ++
 rtl/bitrev_bank_mem.sv | 21 ++
 rtl/bitrev_pingpong.sv | 153 +++++++++++++++
 tb/tb_bitrev_pingpong.sv | 259 +++++++++++++++++++++++++
 4 files changed

// File: rtl/bitrev_pkg.sv
// Shared types and helpers for the ping-pong bit-reversal reorder buffer.
package bitrev_pkg;

   localparam int DESC_KW = 5;
   localparam int REV_W   = 16;

   typedef enum logic [1:0] {
      EMPTY,
      FILLING,
      FULL,
      DRAINING
   } bank_state_e;

   typedef struct packed {
      logic [DESC_KW-1:0] k;
      logic               mode;
   } bank_desc_t;

   // Reversing all REV_W bits and shifting down leaves exactly the low k bits reversed.
   function automatic logic [REV_W-1:0] rev_bits(input logic [REV_W-1:0] addr,
                                                 input logic [DESC_KW-1:0] k);
      logic [REV_W-1:0] r;
      r = {<<{addr}};
      return r >> (DESC_KW'(REV_W) - k);
   endfunction

endpackage

// File: rtl/bitrev_bank_mem.sv
// One reorder bank: simple dual-port RAM, one write and one registered read per cycle.
module bitrev_bank_mem #(
   parameter int AW = 10,
   parameter int DW = 32
) (
   input  logic          clk_i,
   input  logic          we_i,
   input  logic [AW-1:0] waddr_i,
   input  logic [DW-1:0] wdata_i,
   input  logic          re_i,
   input  logic [AW-1:0] raddr_i,
   output logic [DW-1:0] rdata_o
);
   logic [DW-1:0] mem [2**AW];

   always_ff @(posedge clk_i) begin
      if (we_i) mem[waddr_i] <= wdata_i;
      if (re_i) rdata_o <= mem[raddr_i];
   end

endmodule

// File: rtl/bitrev_pingpong.sv
// Streaming bit-reversal reorder buffer: one bank fills in natural order while
// the other drains in natural or bit-reversed order.
module bitrev_pingpong
   import bitrev_pkg::*;
#(
   parameter  int KMAX = 10,
   parameter  int DW   = 32,
   localparam int KW   = $clog2(KMAX + 1)
) (
   input  logic          clk_i,
   input  logic          rst_i,
   input  logic [KW-1:0] cfg_k_i,
   input  logic          cfg_mode_i,
   input  logic          valid_i,
   input  logic [DW-1:0] data_i,
   output logic          ready_o,
   output logic          valid_o,
   output logic [DW-1:0] data_o,
   output logic          last_o,
   input  logic          ready_i,
   output logic [15:0]   frames_o
);
   localparam logic [KMAX-1:0] ONES = '1;

   bank_state_e     state [2];
   bank_desc_t      desc  [2];
   logic            wsel, rsel;
   logic [KMAX-1:0] wcnt, rcnt;
   logic            rd_done;
   logic            rv_q, rlast_q, rbank_q;
   logic            skid_v, skid_l;
   logic [DW-1:0]   skid_d;
   logic [DW-1:0]   rdata [2];

   logic            wr_acc, wr_last, rd_issue, rd_last, pop, room;
   bank_desc_t      wr_desc, rd_desc;
   logic [KMAX-1:0] rd_addr;
   logic [1:0]      load;
   logic [DW-1:0]   push_d;

   always_comb begin
      ready_o = !rst_i && (state[wsel] == EMPTY || state[wsel] == FILLING);
      wr_acc  = valid_i && ready_o;
      wr_desc = desc[wsel];
      if (state[wsel] == EMPTY) begin
         wr_desc.k    = (int'(cfg_k_i) > KMAX) ? DESC_KW'(KMAX) : DESC_KW'(cfg_k_i);
         wr_desc.mode = cfg_mode_i;
      end
      wr_last = (wcnt == ~(ONES << wr_desc.k));

      // Credit: output reg + skid entry + the read in flight must never exceed two.
      pop      = valid_o && ready_i;
      load     = 2'(valid_o) + 2'(skid_v) + 2'(rv_q);
      room     = (load < 2'd2) || (load == 2'd2 && pop);
      rd_desc  = desc[rsel];
      rd_issue = (state[rsel] == DRAINING) && !rd_done && room;
      rd_last  = (rcnt == ~(ONES << rd_desc.k));
      rd_addr  = rd_desc.mode ? KMAX'(rev_bits(REV_W'(rcnt), rd_desc.k)) : rcnt;
      push_d   = rdata[rbank_q];
   end

   for (genvar b = 0; b < 2; b++) begin : g_bank
      bitrev_bank_mem #(.AW(KMAX), .DW(DW)) u_mem (
         .clk_i   (clk_i),
         .we_i    (wr_acc && (wsel == 1'(b))),
         .waddr_i (wcnt),
         .wdata_i (data_i),
         .re_i    (rd_issue && (rsel == 1'(b))),
         .raddr_i (rd_addr),
         .rdata_o (rdata[b])
      );
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state[0] <= EMPTY;
         state[1] <= EMPTY;
         desc[0]  <= '0;
         desc[1]  <= '0;
         wsel     <= 1'b0;
         rsel     <= 1'b0;
         wcnt     <= '0;
         rcnt     <= '0;
         rd_done  <= 1'b0;
         rv_q     <= 1'b0;
         rlast_q  <= 1'b0;
         rbank_q  <= 1'b0;
         skid_v   <= 1'b0;
         skid_l   <= 1'b0;
         skid_d   <= '0;
         valid_o  <= 1'b0;
         data_o   <= '0;
         last_o   <= 1'b0;
         frames_o <= '0;
      end else begin
         if (wr_acc) begin
            desc[wsel] <= wr_desc;
            if (wr_last) begin
               state[wsel] <= FULL;
               wcnt        <= '0;
               wsel        <= !wsel;
            end else begin
               state[wsel] <= FILLING;
               wcnt        <= wcnt + 1'b1;
            end
         end

         if (state[rsel] == FULL) state[rsel] <= DRAINING;

         rv_q <= rd_issue;
         if (rd_issue) begin
            rlast_q <= rd_last;
            rbank_q <= rsel;
            if (rd_last) begin
               rcnt    <= '0;
               rd_done <= 1'b1;
            end else begin
               rcnt <= rcnt + 1'b1;
            end
         end

         // Output register is the head of a 2-deep queue; skid is the tail.
         if (!valid_o || ready_i) begin
            if (skid_v) begin
               valid_o <= 1'b1;
               data_o  <= skid_d;
               last_o  <= skid_l;
               skid_v  <= rv_q;
               skid_d  <= push_d;
               skid_l  <= rlast_q;
            end else begin
               valid_o <= rv_q;
               if (rv_q) begin
                  data_o <= push_d;
                  last_o <= rlast_q;
               end
            end
         end else if (rv_q) begin
            skid_v <= 1'b1;
            skid_d <= push_d;
            skid_l <= rlast_q;
         end

         if (pop && last_o) begin
            state[rsel] <= EMPTY;
            rsel        <= !rsel;
            rd_done     <= 1'b0;
            frames_o    <= frames_o + 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_bitrev_pingpong.sv
// Directed self-checking bench for bitrev_pingpong.
module tb_bitrev_pingpong;
   localparam int KMAX = 10;
   localparam int DW   = 32;
   localparam int KW   = $clog2(KMAX + 1);

   typedef struct {
      logic [DW-1:0] d;
      logic [KW-1:0] k;
      logic          m;
      logic          first;
      int            fidx;
   } beat_t;

   typedef struct {
      logic [DW-1:0] d;
      logic          last;
   } out_t;

   logic          clk = 1'b0;
   logic          rst_i;
   logic [KW-1:0] cfg_k_i;
   logic          cfg_mode_i;
   logic          valid_i;
   logic [DW-1:0] data_i;
   logic          ready_o;
   logic          valid_o;
   logic [DW-1:0] data_o;
   logic          last_o;
   logic          ready_i;
   logic [15:0]   frames_o;

   int checks = 0;
   int errors = 0;
   int rpol = 0;
   int stall_first [4];
   int stall_mid;

   beat_t in_q  [$];
   out_t  exp_q [$];
   out_t  out_q [$];

   logic          prev_stall = 1'b0;
   logic [DW-1:0] prev_d = '0;
   logic          prev_l = 1'b0;

   always #5 clk = ~clk;

   bitrev_pingpong #(.KMAX(KMAX), .DW(DW)) dut (
      .clk_i      (clk),
      .rst_i      (rst_i),
      .cfg_k_i    (cfg_k_i),
      .cfg_mode_i (cfg_mode_i),
      .valid_i    (valid_i),
      .data_i     (data_i),
      .ready_o    (ready_o),
      .valid_o    (valid_o),
      .data_o     (data_o),
      .last_o     (last_o),
      .ready_i    (ready_i),
      .frames_o   (frames_o)
   );

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   function automatic int unsigned tb_rev(input int unsigned v, input int unsigned k);
      int unsigned r;
      r = 0;
      for (int unsigned b = 0; b < k; b++)
         if (((v >> b) & 32'd1) != 0) r = r | (32'd1 << (k - 1 - b));
      return r;
   endfunction

   // Later beats carry deliberately different cfg values, which must be ignored.
   task automatic add_frame(input int unsigned k_cfg, input logic mode,
                            input logic [DW-1:0] base, input int fidx);
      int unsigned k;
      int unsigned n;
      beat_t b;
      out_t  e;
      k = (k_cfg > KMAX) ? KMAX : k_cfg;
      n = 32'd1 << k;
      for (int unsigned i = 0; i < n; i++) begin
         b.d     = base + i;
         b.k     = (i == 0) ? KW'(k_cfg) : KW'(1);
         b.m     = (i == 0) ? mode : !mode;
         b.first = (i == 0);
         b.fidx  = fidx;
         in_q.push_back(b);
         e.d    = base + (mode ? tb_rev(i, k) : i);
         e.last = (i == n - 1);
         exp_q.push_back(e);
      end
   endtask

   task automatic drive(input string tag, input int budget, input int want_out);
      int cyc;
      cyc = 0;
      @(posedge clk); #1;
      while ((in_q.size() > 0 || out_q.size() < want_out) && cyc < budget) begin
         if (in_q.size() > 0) begin
            valid_i    = 1'b1;
            data_i     = in_q[0].d;
            cfg_k_i    = in_q[0].k;
            cfg_mode_i = in_q[0].m;
         end else begin
            valid_i = 1'b0;
         end
         case (rpol)
            0:       ready_i = 1'b1;
            1:       ready_i = 1'($urandom_range(0, 1));
            default: ready_i = 1'b0;
         endcase
         @(negedge clk);
         if (valid_i && ready_o) begin
            void'(in_q.pop_front());
         end else if (valid_i) begin
            if (in_q[0].first) stall_first[in_q[0].fidx]++;
            else stall_mid++;
         end
         @(posedge clk); #1;
         cyc++;
      end
      valid_i = 1'b0;
      check({tag, "_done"}, 64'(in_q.size() == 0 && out_q.size() >= want_out), 64'd1);
   endtask

   task automatic check_out(input string tag);
      check({tag, "_count"}, 64'(out_q.size()), 64'(exp_q.size()));
      for (int i = 0; i < exp_q.size() && i < out_q.size(); i++) begin
         check($sformatf("%s_d%0d", tag, i), 64'(out_q[i].d), 64'(exp_q[i].d));
         check($sformatf("%s_last%0d", tag, i), 64'(out_q[i].last), 64'(exp_q[i].last));
      end
      out_q.delete();
      exp_q.delete();
   endtask

   // Output monitor: collects accepted beats and checks stability under stall.
   always @(negedge clk) begin
      if (rst_i) begin
         prev_stall = 1'b0;
      end else begin
         if (prev_stall) begin
            check("hold_valid", 64'(valid_o), 64'd1);
            check("hold_data", 64'(data_o), 64'(prev_d));
            check("hold_last", 64'(last_o), 64'(prev_l));
         end
         if (valid_o && ready_i) out_q.push_back('{d: data_o, last: last_o});
         prev_stall = valid_o && !ready_i;
         prev_d     = data_o;
         prev_l     = last_o;
      end
   end

   initial begin
      logic [DW-1:0] rev3 [8];
      rev3 = '{0, 4, 2, 6, 1, 5, 3, 7};
      rst_i = 1'b1; valid_i = 1'b0; data_i = '0; cfg_k_i = '0; cfg_mode_i = 1'b0; ready_i = 1'b0;

      // Reset state
      @(negedge clk);
      check("rst_valid_o", 64'(valid_o), 64'd0);
      check("rst_ready_o", 64'(ready_o), 64'd0);
      check("rst_data_o", 64'(data_o), 64'd0);
      check("rst_last_o", 64'(last_o), 64'd0);
      check("rst_frames_o", 64'(frames_o), 64'd0);
      @(posedge clk); #1 rst_i = 1'b0;
      @(negedge clk);
      check("idle_ready_o", 64'(ready_o), 64'd1);
      check("idle_valid_o", 64'(valid_o), 64'd0);

      // 1: k=3 bit-reverse, literal order 0,4,2,6,1,5,3,7
      rpol = 0;
      add_frame(3, 1'b1, 32'd0, 0);
      drive("t1", 100, 8);
      for (int i = 0; i < 8 && i < out_q.size(); i++)
         check($sformatf("t1_lit%0d", i), 64'(out_q[i].d), 64'(rev3[i]));
      check_out("t1");
      check("t1_frames", 64'(frames_o), 64'd1);

      // 2: three back-to-back k=10 frames
      stall_first = '{0, 0, 0, 0};
      stall_mid   = 0;
      for (int f = 0; f < 3; f++) add_frame(10, 1'b1, DW'(f) << 16, f);
      drive("t2", 5000, 3072);
      check("t2_stall_first0", 64'(stall_first[0]), 64'd0);
      check("t2_stall_first1", 64'(stall_first[1]), 64'd0);
      check("t2_stall_mid", 64'(stall_mid), 64'd0);
      check_out("t2");
      check("t2_frames", 64'(frames_o), 64'd4);

      // 3: k=4 pass-through with random backpressure
      rpol = 1;
      add_frame(4, 1'b0, 32'h30, 0);
      drive("t3", 400, 16);
      check_out("t3");
      check("t3_frames", 64'(frames_o), 64'd5);

      // 4: k=2 then k=5 queued, noisy cfg mid-frame
      rpol = 0;
      add_frame(2, 1'b1, 32'h40, 0);
      add_frame(5, 1'b1, 32'h100, 1);
      drive("t4", 300, 36);
      check_out("t4");
      check("t4_frames", 64'(frames_o), 64'd7);

      // 5: two frames with ready_i low, third frame must stall
      rpol = 2;
      add_frame(3, 1'b1, 32'hA0, 0);
      add_frame(3, 1'b1, 32'hB0, 1);
      drive("t5_fill", 100, 0);
      repeat (3) @(posedge clk);
      #1;
      valid_i = 1'b1; data_i = 32'hC0; cfg_k_i = 4'd3; cfg_mode_i = 1'b1;
      @(negedge clk);
      check("t5_ready_blocked", 64'(ready_o), 64'd0);
      check("t5_valid_held", 64'(valid_o), 64'd1);
      check("t5_head_data", 64'(data_o), 64'hA0);
      valid_i = 1'b0;
      rpol = 0;
      add_frame(3, 1'b1, 32'hC0, 2);
      drive("t5", 300, 24);
      check_out("t5");
      check("t5_frames", 64'(frames_o), 64'd10);

      // 7: boundaries k=0 (single word) and cfg_k above KMAX (clamped)
      add_frame(0, 1'b1, 32'h55, 0);
      add_frame(15, 1'b1, 32'h10000, 1);
      drive("t7", 3000, 1025);
      check_out("t7");
      check("t7_frames", 64'(frames_o), 64'd12);

      // 6: reset mid-drain, then a fresh k=3 frame
      add_frame(4, 1'b1, 32'h60, 0);
      drive("t6_pre", 200, 5);
      rst_i = 1'b1;
      @(posedge clk); #1 rst_i = 1'b0;
      @(negedge clk);
      check("t6_valid_o", 64'(valid_o), 64'd0);
      check("t6_ready_o", 64'(ready_o), 64'd1);
      check("t6_frames_o", 64'(frames_o), 64'd0);
      out_q.delete();
      exp_q.delete();
      add_frame(3, 1'b1, 32'h70, 0);
      drive("t6", 100, 8);
      check_out("t6");
      check("t6_frames", 64'(frames_o), 64'd1);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
